// File: rtl/ddr_cmd_sequencer_if.sv
// Request handshake plus DDR command/status bundle between the sequencer
// (master) and the requester/DIMM side (slave).
interface ddr_cmd_sequencer_if #(
  parameter int BANK_W = 4,
  parameter int ROW_W  = 15,
  parameter int COL_W  = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic              req_pre;
  logic [3:0]        req_bl;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;

  logic              act_cmd;
  logic              rd_cmd;
  logic              wr_cmd;
  logic              pre_cmd;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;

  logic              dev_busy;
  logic              next_cmd;
  logic              dev_rd;
  logic [1:0]        dev_rw;

  modport master (
    input  req_valid, req_rw, req_pre, req_bl, req_bank, req_row, req_col,
    output req_ready, act_cmd, rd_cmd, wr_cmd, pre_cmd,
           cmd_bank, cmd_row, cmd_col, dev_busy, next_cmd, dev_rd, dev_rw
  );

  modport slave (
    output req_valid, req_rw, req_pre, req_bl, req_bank, req_row, req_col,
    input  req_ready, act_cmd, rd_cmd, wr_cmd, pre_cmd,
           cmd_bank, cmd_row, cmd_col, dev_busy, next_cmd, dev_rd, dev_rw
  );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Single-requester DDR4 command sequencer: ACT -> RD/WR -> optional PRE with
// tRCD/CL/CWL/burst/tRP timing and a single tracked open row.
module ddr_cmd_sequencer #(
  parameter int T_RCD  = 4,
  parameter int T_CL   = 5,
  parameter int T_CWL  = 4,
  parameter int T_RP   = 3,
  parameter int BANK_W = 4,
  parameter int ROW_W  = 15,
  parameter int COL_W  = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  ddr_cmd_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_TRCD, S_CAS, S_DATA, S_PRE, S_TRP
  } state_t;

  state_t            r_state;
  logic [7:0]        r_wait;
  logic              r_rw;
  logic              r_pre;
  logic              r_bc4;
  logic              r_miss;
  logic              r_row_open;
  logic [BANK_W-1:0] r_bank;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [BANK_W-1:0] r_open_bank;
  logic [ROW_W-1:0]  r_open_row;
  logic              r_act;
  logic              r_rd;
  logic              r_wr;
  logic              r_prec;
  logic [BANK_W-1:0] r_cmd_bank;
  logic [ROW_W-1:0]  r_cmd_row;
  logic [COL_W-1:0]  r_cmd_col;

  logic w_idle;
  logic w_hit;
  logic w_xfer;

  // Wait states exit when the counter reaches zero, so each load is length-1.
  function automatic logic [7:0] data_load(input logic rw, input logic bc4);
    int len;
    len = (rw ? T_CL : T_CWL) + (bc4 ? 2 : 4);
    return 8'(len - 1);
  endfunction

  assign w_idle = (r_state == S_IDLE);
  assign w_hit  = r_row_open && (bus.req_bank == r_open_bank) &&
                  (bus.req_row == r_open_row);
  assign w_xfer = (r_state == S_CAS) || (r_state == S_DATA);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_rw        <= 1'b0;
      r_pre       <= 1'b0;
      r_bc4       <= 1'b0;
      r_miss      <= 1'b0;
      r_row_open  <= 1'b0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_open_bank <= '0;
      r_open_row  <= '0;
      r_act       <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_prec      <= 1'b0;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
    end else begin
      r_act  <= 1'b0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_prec <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_rw   <= bus.req_rw;
            r_pre  <= bus.req_pre;
            r_bc4  <= (bus.req_bl == 4'd4);
            r_bank <= bus.req_bank;
            r_row  <= bus.req_row;
            r_col  <= bus.req_col;
            if (!r_row_open) begin
              r_state     <= S_ACT;
              r_act       <= 1'b1;
              r_cmd_bank  <= bus.req_bank;
              r_cmd_row   <= bus.req_row;
              r_row_open  <= 1'b1;
              r_open_bank <= bus.req_bank;
              r_open_row  <= bus.req_row;
            end else if (w_hit) begin
              r_state    <= S_CAS;
              r_rd       <= bus.req_rw;
              r_wr       <= !bus.req_rw;
              r_cmd_bank <= bus.req_bank;
              r_cmd_col  <= bus.req_col;
            end else begin
              r_state    <= S_PRE;
              r_miss     <= 1'b1;
              r_prec     <= 1'b1;
              r_cmd_bank <= r_open_bank;
              r_row_open <= 1'b0;
            end
          end
        end
        S_ACT: begin
          r_state <= S_TRCD;
          r_wait  <= 8'(T_RCD - 2);
        end
        S_TRCD: begin
          if (r_wait == 8'd0) begin
            r_state    <= S_CAS;
            r_rd       <= r_rw;
            r_wr       <= !r_rw;
            r_cmd_bank <= r_bank;
            r_cmd_col  <= r_col;
          end else begin
            r_wait <= r_wait - 8'd1;
          end
        end
        S_CAS: begin
          r_state <= S_DATA;
          r_wait  <= data_load(r_rw, r_bc4);
        end
        S_DATA: begin
          if (r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
          end else if (r_pre) begin
            r_state    <= S_PRE;
            r_miss     <= 1'b0;
            r_prec     <= 1'b1;
            r_cmd_bank <= r_open_bank;
            r_row_open <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PRE: begin
          r_state <= S_TRP;
          r_wait  <= 8'(T_RP - 2);
        end
        S_TRP: begin
          if (r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
          end else if (r_miss) begin
            // The missed request re-opens its own row once tRP has elapsed.
            r_state     <= S_ACT;
            r_miss      <= 1'b0;
            r_act       <= 1'b1;
            r_cmd_bank  <= r_bank;
            r_cmd_row   <= r_row;
            r_row_open  <= 1'b1;
            r_open_bank <= r_bank;
            r_open_row  <= r_row;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.dev_busy  = !w_idle;
  assign bus.act_cmd   = r_act;
  assign bus.rd_cmd    = r_rd;
  assign bus.wr_cmd    = r_wr;
  assign bus.pre_cmd   = r_prec;
  assign bus.cmd_bank  = r_cmd_bank;
  assign bus.cmd_row   = r_cmd_row;
  assign bus.cmd_col   = r_cmd_col;
  assign bus.next_cmd  = (r_state == S_DATA) && (r_wait == 8'd0);
  assign bus.dev_rd    = w_xfer && r_rw;
  assign bus.dev_rw    = w_xfer ? (r_rw ? 2'b01 : 2'b10) : 2'b00;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Scoreboard bench for ddr_cmd_sequencer: directed requests push expected
// command events; a negedge monitor pops and compares every strobe.
module tb_ddr_cmd_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ddr_cmd_sequencer_if #(.BANK_W(4), .ROW_W(15), .COL_W(10)) bus ();

  ddr_cmd_sequencer #(
    .T_RCD(4), .T_CL(5), .T_CWL(4), .T_RP(3),
    .BANK_W(4), .ROW_W(15), .COL_W(10)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [4:0] K_ACT = 5'b10000;
  localparam logic [4:0] K_RD  = 5'b01000;
  localparam logic [4:0] K_WR  = 5'b00100;
  localparam logic [4:0] K_PRE = 5'b00010;
  localparam logic [4:0] K_NXT = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] kind;
    logic [3:0] bank;
    logic [14:0] addr;
  } ev_t;

  ev_t q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cnt01 = 0, cnt10 = 0, cnt_rd = 0, cnt_busy = 0;

  function automatic void push(int c, logic [4:0] k, logic [3:0] b, logic [14:0] a);
    ev_t e;
    e.cyc = c; e.kind = k; e.bank = b; e.addr = a;
    q.push_back(e);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every visible strobe must match the head of the expectation queue.
  always @(negedge clock) begin : mon
    logic [4:0] k;
    ev_t        e;
    logic       ok;
    if (reset_n) begin
      if (bus.dev_rw == 2'b01) cnt01++;
      if (bus.dev_rw == 2'b10) cnt10++;
      if (bus.dev_rd) cnt_rd++;
      if (bus.dev_busy) cnt_busy++;
      k = {bus.act_cmd, bus.rd_cmd, bus.wr_cmd, bus.pre_cmd, bus.next_cmd};
      if (k != 5'b0) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: kind %b at cycle %0d, none expected", k, cyc);
        end else begin
          e  = q.pop_front();
          ok = (k == e.kind) && (cyc == e.cyc);
          if (k[4])        ok = ok && (bus.cmd_bank == e.bank) && (bus.cmd_row == e.addr);
          if (k[3] | k[2]) ok = ok && (bus.cmd_bank == e.bank) && (bus.cmd_col == e.addr[9:0]);
          if (k[1])        ok = ok && (bus.cmd_bank == e.bank);
          if (!ok) begin
            n_bad++;
            $display("FAIL event: got kind %b cyc %0d bank %0d row %h col %h; expected kind %b cyc %0d bank %0d addr %h",
                     k, cyc, bus.cmd_bank, bus.cmd_row, bus.cmd_col, e.kind, e.cyc, e.bank, e.addr);
          end
        end
      end
    end
  end

  task automatic clr_cnt();
    cnt01 = 0; cnt10 = 0; cnt_rd = 0; cnt_busy = 0;
  endtask

  task automatic drive(logic rw, logic pre, logic [3:0] bl, logic [3:0] bank,
                       logic [14:0] row, logic [9:0] col);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_pre   = pre;
    bus.req_bl    = bl;
    bus.req_bank  = bank;
    bus.req_row   = row;
    bus.req_col   = col;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(string name, int exp_cyc);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: req_ready never returned, expected at cycle %0d", name, exp_cyc);
    end else begin
      chk({name, "_idle_cycle"}, cyc, exp_cyc);
    end
  endtask

  int t;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_pre   = 1'b0;
    bus.req_bl    = 4'd8;
    bus.req_bank  = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_strobes", int'({bus.act_cmd, bus.rd_cmd, bus.wr_cmd, bus.pre_cmd, bus.next_cmd}), 0);
    chk("rst_busy", int'(bus.dev_busy), 0);
    chk("rst_dev_rw", int'(bus.dev_rw), 0);
    chk("rst_ready", int'(bus.req_ready), 1);
    reset_n = 1'b1;
    @(negedge clock);

    // Closed-bank read with auto-precharge, BL8
    clr_cnt(); t = cyc;
    push(t + 1,  K_ACT, 4'd2, 15'h10);
    push(t + 5,  K_RD,  4'd2, 15'h3);
    push(t + 14, K_NXT, 4'd0, 15'h0);
    push(t + 15, K_PRE, 4'd2, 15'h0);
    drive(1'b1, 1'b1, 4'd8, 4'd2, 15'h10, 10'h3);
    wait_idle("rd_closed", t + 18);
    chk("rd_closed_rw01", cnt01, 10);
    chk("rd_closed_devrd", cnt_rd, 10);
    chk("rd_closed_busy", cnt_busy, 17);

    // Closed-bank write BL8, row left open
    clr_cnt(); t = cyc;
    push(t + 1,  K_ACT, 4'd2, 15'h10);
    push(t + 5,  K_WR,  4'd2, 15'h4);
    push(t + 13, K_NXT, 4'd0, 15'h0);
    drive(1'b0, 1'b0, 4'd8, 4'd2, 15'h10, 10'h4);
    wait_idle("wr_open", t + 14);
    chk("wr_open_rw10", cnt10, 9);

    // Write BC4 row hit: no ACT
    clr_cnt(); t = cyc;
    push(t + 1, K_WR,  4'd2, 15'h7);
    push(t + 7, K_NXT, 4'd0, 15'h0);
    drive(1'b0, 1'b0, 4'd4, 4'd2, 15'h10, 10'h7);
    wait_idle("wr_hit", t + 8);
    chk("wr_hit_rw10", cnt10, 7);
    chk("wr_hit_devrd", cnt_rd, 0);

    // Row miss in the same bank
    clr_cnt(); t = cyc;
    push(t + 1,  K_PRE, 4'd2, 15'h0);
    push(t + 4,  K_ACT, 4'd2, 15'h20);
    push(t + 8,  K_RD,  4'd2, 15'h5);
    push(t + 17, K_NXT, 4'd0, 15'h0);
    drive(1'b1, 1'b0, 4'd8, 4'd2, 15'h20, 10'h5);
    wait_idle("rd_miss", t + 18);
    chk("rd_miss_rw01", cnt01, 10);

    // Miss to another bank: PRE targets the open bank, BC4 read
    clr_cnt(); t = cyc;
    push(t + 1,  K_PRE, 4'd2, 15'h0);
    push(t + 4,  K_ACT, 4'd5, 15'h20);
    push(t + 8,  K_RD,  4'd5, 15'h9);
    push(t + 15, K_NXT, 4'd0, 15'h0);
    drive(1'b1, 1'b0, 4'd4, 4'd5, 15'h20, 10'h9);
    wait_idle("rd_bank_miss", t + 16);
    chk("rd_bank_miss_rw01", cnt01, 8);

    // Hit read interrupted by reset mid-DATA
    clr_cnt(); t = cyc;
    push(t + 1, K_RD, 4'd5, 15'h11);
    drive(1'b1, 1'b0, 4'd8, 4'd5, 15'h20, 10'h11);
    while (cyc < t + 4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_dev_rw", int'(bus.dev_rw), 0);
    chk("async_rst_busy", int'(bus.dev_busy), 0);
    chk("async_rst_ready", int'(bus.req_ready), 1);
    chk("async_rst_dev_rd", int'(bus.dev_rd), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk("async_rst_queue", q.size(), 0);
    @(negedge clock);

    // Previously open row must be re-activated; req_bl=6 behaves as BL8
    clr_cnt(); t = cyc;
    push(t + 1,  K_ACT, 4'd5, 15'h20);
    push(t + 5,  K_RD,  4'd5, 15'h22);
    push(t + 14, K_NXT, 4'd0, 15'h0);
    push(t + 15, K_PRE, 4'd5, 15'h0);
    drive(1'b1, 1'b1, 4'd6, 4'd5, 15'h20, 10'h22);
    wait_idle("rd_bl6", t + 18);
    chk("rd_bl6_rw01", cnt01, 10);

    repeat (4) @(negedge clock);
    chk("final_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ddr_cmd_sequencer.md
Name: ddr_cmd_sequencer

Overview:
Single-requester DDR4 command sequencer between the transaction generator and the DIMM model. Accepts one read/write request at a time and issues ACT, RD/WR and PRE in order, honouring tRCD, CL/CWL, burst duration and tRP. Drives the shared status handshake (dev_busy, next_cmd, dev_rd, dev_rw) seen by the DIMM model and the memory checker. Tracks a single open row so back-to-back hits skip the ACT.

Parameters:
T_RCD, 4, ACT-to-CAS delay in clocks (>=2)
T_CL, 5, read CAS latency in clocks (>=1)
T_CWL, 4, write CAS latency in clocks (>=1)
T_RP, 3, PRE-to-ACT/idle delay in clocks (>=2)
BANK_W, 4, bank-group+bank address width
ROW_W, 15, row address width
COL_W, 10, column address width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (combinational: state==IDLE)
req_rw  in  1  1=read, 0=write
req_pre  in  1  1=precharge after access (RD_PRE), 0=leave row open
req_bl  in  4  burst length, 8 or 4 (BC4)
req_bank  in  BANK_W  bank
req_row  in  ROW_W  row
req_col  in  COL_W  column
act_cmd  out  1  ACT strobe, one cycle
rd_cmd  out  1  RD strobe, one cycle
wr_cmd  out  1  WR strobe, one cycle
pre_cmd  out  1  PRE strobe, one cycle
cmd_bank  out  BANK_W  bank for current command
cmd_row  out  ROW_W  row for ACT
cmd_col  out  COL_W  column for RD/WR
dev_busy  out  1  1 whenever state!=IDLE
next_cmd  out  1  one-cycle pulse on last data cycle of a burst
dev_rd  out  1  1 from CAS through DATA for reads
dev_rw  out  2  01=read, 10=write in CAS/DATA; 00 otherwise

Behaviour:
- Reset: state=IDLE, row_open=0, wait_cnt=0; all outputs 0 except req_ready=1. Reset takes effect immediately in any state and abandons an in-flight request; no PRE is issued for it.
- Accept on req_valid && req_ready; latch rw, pre, bl, bank, row, col. req_bl other than 4 is treated as 8.
- IDLE->ACT if !row_open; ->CAS if row_open and bank/row match; ->PRE (miss) otherwise.
- ACT: act_cmd=1, cmd_bank/cmd_row driven; set row_open, open_bank, open_row; then TRCD waits T_RCD-1 cycles; ->CAS. ACT-to-CAS = T_RCD clocks.
- CAS: rd_cmd or wr_cmd=1, cmd_bank/cmd_col driven; dev_rw/dev_rd asserted from this cycle.
- DATA: lasts (rw ? T_CL : T_CWL) + bl/2 cycles; next_cmd=1 on its final cycle. Then ->PRE if latched pre=1, else ->IDLE.
- PRE: pre_cmd=1, cmd_bank=open_bank, clear row_open; then TRP waits T_RP-1 cycles. Exit goes ->ACT on a miss, ->IDLE after an auto-precharge. PRE-to-next = T_RP clocks.
- Command strobes are mutually exclusive and registered. cmd_* fields hold their last value when no strobe is active.
- wait_cnt is an 8-bit down-counter loaded on state entry. Parameters must keep every delay <=255.
- New requests are never accepted outside IDLE; req_valid held high is accepted on the IDLE cycle.

Test Plan:
- Reset: reset_n low for 3 clocks -> all strobes, dev_busy, dev_rw = 0; req_ready=1.
- Read, closed, req_pre=1, BL8, bank 2 row 0x10, accepted cycle 0 -> act_cmd@1, rd_cmd@5, dev_rw=01 cycles 5-14, next_cmd@14, pre_cmd@15, req_ready@18.
- Write hit after the above with req_pre=0 then write BL4 same bank/row accepted @t -> no act_cmd, wr_cmd@t+1, next_cmd@t+7, IDLE @t+8, dev_rw=10 cycles t+1..t+7.
- Row miss: row 0x10 open in bank 2, read row 0x20 accepted @t -> pre_cmd@t+1, act_cmd@t+4 (cmd_row=0x20), rd_cmd@t+8.
- Reset asserted mid-DATA -> outputs 0 asynchronously, row_open cleared. Next request to previously open row issues act_cmd (no hit).
- req_bl=6 read, closed bank -> DATA lasts T_CL+4=9 cycles, same as BL8.
